// File: rtl/sb_rx_data_decoder.sv
// Sideband RX data decoder: pairs decoded headers with their 64-bit data word,
// extracts the packed field and checks fixed-pattern / zero-padding bits.
module sb_rx_data_decoder #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hdr_valid,
    input  logic        i_hdr_has_data,
    input  logic [3:0]  i_msg_no,
    input  logic [3:0]  i_state,
    input  logic [3:0]  i_sub_state,
    input  logic        i_rdi_msg,
    input  logic        i_tx_point_sweep_test_en,
    input  logic [1:0]  i_tx_point_sweep_test,
    input  logic        i_deser_valid,
    input  logic [63:0] i_deser_data,
    output logic        o_msg_valid,
    output logic        o_data_valid,
    output logic [15:0] o_data_bus,
    output logic [3:0]  o_msg_no,
    output logic        o_fmt_err,
    output logic        o_seq_err,
    output logic        o_timeout_err,
    output logic        o_busy
);

    typedef enum logic {ST_IDLE, ST_WAIT_DATA} state_t;

    localparam logic [7:0]  CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0] PT_ONES    = 64'hFFFF << 43;
    localparam logic [63:0] PT_FIELD   = (64'h1 << 59) | (64'h1 << 11) | (64'h1 << 7) |
                                         (64'h1 << 6) | 64'h1;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;

    logic [3:0]  ctx_msg_no_reg, ctx_state_reg, ctx_sub_reg;
    logic        ctx_rdi_reg, ctx_test_en_reg;
    logic [1:0]  ctx_test_reg;

    logic        msg_valid_reg, msg_valid_next;
    logic        data_valid_reg, data_valid_next;
    logic [15:0] data_bus_reg, data_bus_next;
    logic [3:0]  msg_no_reg, msg_no_next;
    logic        fmt_err_reg, fmt_err_next;
    logic        seq_err_reg, seq_err_next;
    logic        timeout_err_reg, timeout_err_next;
    logic        busy_reg, busy_next;

    // A same-cycle header always owns the word, so decode against it when present.
    logic [3:0]  dec_msg_no, dec_state, dec_sub;
    logic        dec_rdi, dec_test_en;
    logic [1:0]  dec_test;
    logic [17:0] dec_result;

    // Returns {field_valid, fmt_err, field}.
    function automatic logic [17:0] decode_word(
        input logic [3:0]  msg_no,
        input logic [3:0]  st,
        input logic [3:0]  sub,
        input logic        rdi,
        input logic        test_en,
        input logic [1:0]  test,
        input logic [63:0] d
    );
        logic [15:0] f;
        logic        v;
        logic        e;
        f = 16'h0;
        v = 1'b0;
        e = |d;
        if (rdi) begin
            v = 1'b0;
        end else if (test_en) begin
            if (msg_no == 4'd1) begin
                v = 1'b1;
                f = {11'b0, d[59], d[11], d[7], d[6], d[0]};
                e = ((d & PT_ONES) != PT_ONES) || ((d & ~(PT_ONES | PT_FIELD)) != 64'h0);
            end else if (((test == 2'd0 || test == 2'd2) && msg_no == 4'd6) ||
                         (test == 2'd3 && msg_no == 4'd9)) begin
                v = 1'b1;
                f = d[15:0];
                e = |d[63:16];
            end
        end else if (st == 4'd3 && sub == 4'd0 && msg_no != 4'd0) begin
            v = 1'b1;
            f = {5'b0, d[10:0]};
            e = |d[63:11];
        end else if (st == 4'd3 && sub == 4'd4 && msg_no == 4'd6) begin
            v = 1'b1;
            f = d[15:0];
            e = |d[63:16];
        end
        return {v, e, f};
    endfunction

    always_comb begin
        dec_msg_no  = i_hdr_valid ? i_msg_no                 : ctx_msg_no_reg;
        dec_state   = i_hdr_valid ? i_state                  : ctx_state_reg;
        dec_sub     = i_hdr_valid ? i_sub_state              : ctx_sub_reg;
        dec_rdi     = i_hdr_valid ? i_rdi_msg                : ctx_rdi_reg;
        dec_test_en = i_hdr_valid ? i_tx_point_sweep_test_en : ctx_test_en_reg;
        dec_test    = i_hdr_valid ? i_tx_point_sweep_test    : ctx_test_reg;
        dec_result  = decode_word(dec_msg_no, dec_state, dec_sub, dec_rdi,
                                  dec_test_en, dec_test, i_deser_data);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (i_hdr_valid) begin
            state_next = (i_hdr_has_data && !i_deser_valid) ? ST_WAIT_DATA : ST_IDLE;
            cnt_next   = 8'd0;
        end else if (state_reg == ST_WAIT_DATA) begin
            if (i_deser_valid || cnt_reg == CNT_LAST) begin
                state_next = ST_IDLE;
            end else begin
                cnt_next = cnt_reg + 8'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        logic complete;
        logic with_word;
        complete         = 1'b0;
        with_word        = 1'b0;
        msg_valid_next   = 1'b0;
        data_valid_next  = 1'b0;
        fmt_err_next     = 1'b0;
        seq_err_next     = 1'b0;
        timeout_err_next = 1'b0;
        data_bus_next    = data_bus_reg;
        msg_no_next      = msg_no_reg;

        if (i_hdr_valid) begin
            seq_err_next = (state_reg == ST_WAIT_DATA);
            if (!i_hdr_has_data) begin
                complete = 1'b1;
            end else if (i_deser_valid) begin
                complete  = 1'b1;
                with_word = 1'b1;
            end
        end else if (i_deser_valid) begin
            if (state_reg == ST_IDLE) begin
                seq_err_next = 1'b1;
            end else begin
                complete  = 1'b1;
                with_word = 1'b1;
            end
        end else if (state_reg == ST_WAIT_DATA && cnt_reg == CNT_LAST) begin
            timeout_err_next = 1'b1;
        end

        if (complete) begin
            msg_valid_next = 1'b1;
            msg_no_next    = dec_msg_no;
            data_bus_next  = 16'h0;
            if (with_word) begin
                data_valid_next = dec_result[17];
                fmt_err_next    = dec_result[16];
                data_bus_next   = dec_result[17] ? dec_result[15:0] : 16'h0;
            end
        end
        busy_next = (state_next == ST_WAIT_DATA);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctx_msg_no_reg  <= 4'd0;
            ctx_state_reg   <= 4'd0;
            ctx_sub_reg     <= 4'd0;
            ctx_rdi_reg     <= 1'b0;
            ctx_test_en_reg <= 1'b0;
            ctx_test_reg    <= 2'd0;
        end else if (i_hdr_valid) begin
            ctx_msg_no_reg  <= i_msg_no;
            ctx_state_reg   <= i_state;
            ctx_sub_reg     <= i_sub_state;
            ctx_rdi_reg     <= i_rdi_msg;
            ctx_test_en_reg <= i_tx_point_sweep_test_en;
            ctx_test_reg    <= i_tx_point_sweep_test;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msg_valid_reg   <= 1'b0;
            data_valid_reg  <= 1'b0;
            data_bus_reg    <= 16'h0;
            msg_no_reg      <= 4'd0;
            fmt_err_reg     <= 1'b0;
            seq_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            msg_valid_reg   <= msg_valid_next;
            data_valid_reg  <= data_valid_next;
            data_bus_reg    <= data_bus_next;
            msg_no_reg      <= msg_no_next;
            fmt_err_reg     <= fmt_err_next;
            seq_err_reg     <= seq_err_next;
            timeout_err_reg <= timeout_err_next;
            busy_reg        <= busy_next;
        end
    end

    assign o_msg_valid   = msg_valid_reg;
    assign o_data_valid  = data_valid_reg;
    assign o_data_bus    = data_bus_reg;
    assign o_msg_no      = msg_no_reg;
    assign o_fmt_err     = fmt_err_reg;
    assign o_seq_err     = seq_err_reg;
    assign o_timeout_err = timeout_err_reg;
    assign o_busy        = busy_reg;

endmodule

// File: tb/tb_sb_rx_data_decoder.sv
// Bench for sb_rx_data_decoder: tasks drive scenarios and queue expected strobes,
// a negedge monitor pops and compares them against the DUT.
module tb_sb_rx_data_decoder;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_valid = 1'b0, hdr_has_data = 1'b0;
    logic [3:0]  msg_no = 4'd0, st = 4'd0, sub = 4'd0;
    logic        rdi = 1'b0, test_en = 1'b0;
    logic [1:0]  test = 2'd0;
    logic        deser_valid = 1'b0;
    logic [63:0] deser_data = 64'h0;

    logic        o_msg_valid, o_data_valid, o_fmt_err, o_seq_err, o_timeout_err, o_busy;
    logic [15:0] o_data_bus;
    logic [3:0]  o_msg_no;

    sb_rx_data_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_hdr_valid              (hdr_valid),
        .i_hdr_has_data           (hdr_has_data),
        .i_msg_no                 (msg_no),
        .i_state                  (st),
        .i_sub_state              (sub),
        .i_rdi_msg                (rdi),
        .i_tx_point_sweep_test_en (test_en),
        .i_tx_point_sweep_test    (test),
        .i_deser_valid            (deser_valid),
        .i_deser_data             (deser_data),
        .o_msg_valid              (o_msg_valid),
        .o_data_valid             (o_data_valid),
        .o_data_bus               (o_data_bus),
        .o_msg_no                 (o_msg_no),
        .o_fmt_err                (o_fmt_err),
        .o_seq_err                (o_seq_err),
        .o_timeout_err            (o_timeout_err),
        .o_busy                   (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          seq;
        bit          tmo;
        bit          msgv;
        logic [3:0]  no;
        bit          dv;
        logic [15:0] bus;
        bit          fmt;
    } evt_t;

    evt_t sb[$];
    evt_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] PT_WORD = (64'hFFFF << 43) | (64'h1 << 59) | (64'h1 << 7) | 64'h1;
    localparam logic [63:0] PT_BAD  = PT_WORD & ~(64'h1 << 50);

    task automatic push(input int c, input bit seq, input bit tmo, input bit msgv,
                        input logic [3:0] no, input bit dv, input logic [15:0] bus, input bit fmt);
        evt_t e;
        e.cyc = c; e.seq = seq; e.tmo = tmo; e.msgv = msgv;
        e.no = no; e.dv = dv; e.bus = bus; e.fmt = fmt;
        sb.push_back(e);
    endtask

    // One input cycle: drive after a negedge, return at the next negedge.
    task automatic apply(input bit hv, input bit hd, input logic [3:0] no, input logic [3:0] s,
                         input logic [3:0] ss, input bit r, input bit ten, input logic [1:0] t,
                         input bit dv, input logic [63:0] d);
        hdr_valid = hv; hdr_has_data = hd; msg_no = no; st = s; sub = ss;
        rdi = r; test_en = ten; test = t; deser_valid = dv; deser_data = d;
        @(negedge clk);
        hdr_valid = 1'b0; hdr_has_data = 1'b0; msg_no = 4'd0; st = 4'd0; sub = 4'd0;
        rdi = 1'b0; test_en = 1'b0; test = 2'd0; deser_valid = 1'b0; deser_data = 64'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (o_msg_valid || o_seq_err || o_timeout_err) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe cyc=%0d got seq=%b tmo=%b msg=%b required none",
                         cyc, o_seq_err, o_timeout_err, o_msg_valid);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || o_seq_err !== mon_e.seq || o_timeout_err !== mon_e.tmo ||
                    o_msg_valid !== mon_e.msgv) begin
                    n_bad++;
                    $display("FAIL strobe cyc=%0d got seq=%b tmo=%b msg=%b required cyc=%0d seq=%b tmo=%b msg=%b",
                             cyc, o_seq_err, o_timeout_err, o_msg_valid,
                             mon_e.cyc, mon_e.seq, mon_e.tmo, mon_e.msgv);
                end else begin
                    $display("cyc=%0d strobe seq=%b tmo=%b msg=%b ok", cyc,
                             o_seq_err, o_timeout_err, o_msg_valid);
                end
                if (mon_e.msgv) begin
                    n_cmp++;
                    if (o_msg_no !== mon_e.no || o_data_valid !== mon_e.dv ||
                        o_data_bus !== mon_e.bus || o_fmt_err !== mon_e.fmt) begin
                        n_bad++;
                        $display("FAIL payload cyc=%0d got no=%0d dv=%b bus=%h fmt=%b required no=%0d dv=%b bus=%h fmt=%b",
                                 cyc, o_msg_no, o_data_valid, o_data_bus, o_fmt_err,
                                 mon_e.no, mon_e.dv, mon_e.bus, mon_e.fmt);
                    end else begin
                        $display("cyc=%0d msg no=%0d dv=%b bus=%h fmt=%b ok", cyc,
                                 o_msg_no, o_data_valid, o_data_bus, o_fmt_err);
                    end
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_strobe cyc=%0d got none required strobe at cyc=%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    task automatic test_reset();
        idle(3);
        n_cmp++;
        if ({o_msg_valid, o_data_valid, o_fmt_err, o_seq_err, o_timeout_err, o_busy} !== 6'b0 ||
            o_data_bus !== 16'h0 || o_msg_no !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got flags=%b bus=%h no=%0d required 0",
                     {o_msg_valid, o_data_valid, o_fmt_err, o_seq_err, o_timeout_err, o_busy},
                     o_data_bus, o_msg_no);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_param();
        apply(1, 1, 4'd2, 4'd3, 4'd0, 0, 0, 2'd0, 0, 64'h0);
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_bad++; $display("FAIL param_busy_rise got %b required 1", o_busy);
        end
        idle(1);
        push(cyc + 1, 0, 0, 1, 4'd2, 1, 16'h05A3, 0);
        apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 2'd0, 1, 64'h0000_0000_0000_05A3);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("FAIL param_busy_fall got %b required 0", o_busy);
        end
        idle(1);
    endtask

    task automatic test_timeout();
        int t_busy;
        apply(1, 1, 4'd7, 4'd3, 4'd0, 0, 0, 2'd0, 0, 64'h0);
        t_busy = cyc;
        push(t_busy + TMO, 0, 1, 0, 4'd0, 0, 16'h0, 0);
        idle(TMO + 2);
        n_cmp++;
        if (o_busy !== 1'b0 || o_data_bus !== 16'h05A3 || o_msg_no !== 4'd2) begin
            n_bad++;
            $display("FAIL timeout_hold got busy=%b bus=%h no=%0d required busy=0 bus=05a3 no=2",
                     o_busy, o_data_bus, o_msg_no);
        end
        push(cyc + 1, 1, 0, 0, 4'd0, 0, 16'h0, 0);
        apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 2'd0, 1, 64'h1234);
        idle(2);
    endtask

    typedef struct {
        bit          hd;
        logic [3:0]  no;
        logic [3:0]  s;
        logic [3:0]  ss;
        bit          r;
        bit          ten;
        logic [1:0]  t;
        logic [63:0] d;
        bit          dv;
        logic [15:0] bus;
        bit          fmt;
    } stim_t;

    task automatic test_back_to_back();
        stim_t tbl[10];
        tbl[0] = '{1, 4'd1, 4'd0, 4'd0, 0, 1, 2'd0, PT_WORD,               1, 16'h0015, 0};
        tbl[1] = '{1, 4'd1, 4'd0, 4'd0, 0, 1, 2'd0, PT_BAD,                1, 16'h0015, 1};
        tbl[2] = '{1, 4'd9, 4'd0, 4'd0, 0, 1, 2'd3, 64'h1_0000_BEEF,       1, 16'hBEEF, 1};
        tbl[3] = '{0, 4'd5, 4'd0, 4'd0, 1, 0, 2'd0, 64'h0,                 0, 16'h0000, 0};
        tbl[4] = '{1, 4'd6, 4'd0, 4'd0, 0, 1, 2'd1, 64'h12,                0, 16'h0000, 1};
        tbl[5] = '{1, 4'd6, 4'd0, 4'd0, 0, 1, 2'd2, 64'hCAFE,              1, 16'hCAFE, 0};
        tbl[6] = '{1, 4'd3, 4'd3, 4'd0, 0, 0, 2'd0, 64'h800,               1, 16'h0000, 1};
        tbl[7] = '{1, 4'd0, 4'd3, 4'd0, 0, 0, 2'd0, 64'h0,                 0, 16'h0000, 0};
        tbl[8] = '{1, 4'd6, 4'd3, 4'd4, 0, 0, 2'd0, 64'h1_0000,            1, 16'h0000, 1};
        tbl[9] = '{1, 4'd2, 4'd3, 4'd0, 1, 0, 2'd0, 64'h1,                 0, 16'h0000, 1};
        for (int i = 0; i < 10; i++) begin
            push(cyc + 1, 0, 0, 1, tbl[i].no, tbl[i].dv, tbl[i].bus, tbl[i].fmt);
            apply(1, tbl[i].hd, tbl[i].no, tbl[i].s, tbl[i].ss, tbl[i].r, tbl[i].ten,
                  tbl[i].t, tbl[i].hd, tbl[i].d);
        end
        idle(2);
    endtask

    task automatic test_overrun();
        apply(1, 1, 4'd2, 4'd3, 4'd0, 0, 0, 2'd0, 0, 64'h0);
        idle(1);
        push(cyc + 1, 1, 0, 1, 4'd6, 1, 16'h0006, 0);
        apply(1, 1, 4'd6, 4'd3, 4'd4, 0, 0, 2'd0, 1, 64'h6);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("FAIL overrun_busy got %b required 0", o_busy);
        end
        apply(1, 1, 4'd4, 4'd3, 4'd0, 0, 0, 2'd0, 0, 64'h0);
        push(cyc + 1, 1, 0, 0, 4'd0, 0, 16'h0, 0);
        apply(1, 1, 4'd9, 4'd0, 4'd0, 0, 1, 2'd3, 0, 64'h0);
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_bad++; $display("FAIL overrun_nowd_busy got %b required 1", o_busy);
        end
        push(cyc + 1, 0, 0, 1, 4'd9, 1, 16'hABCD, 0);
        apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 2'd0, 1, 64'hABCD);
        idle(2);
    endtask

    task automatic test_reset_wait();
        apply(1, 1, 4'd2, 4'd3, 4'd0, 0, 0, 2'd0, 0, 64'h0);
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_bad++; $display("FAIL rstwait_busy got %b required 1", o_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_msg_valid, o_data_valid, o_fmt_err, o_seq_err, o_timeout_err, o_busy} !== 6'b0 ||
            o_data_bus !== 16'h0 || o_msg_no !== 4'd0) begin
            n_bad++;
            $display("FAIL rstwait_outputs got flags=%b bus=%h no=%0d required 0",
                     {o_msg_valid, o_data_valid, o_fmt_err, o_seq_err, o_timeout_err, o_busy},
                     o_data_bus, o_msg_no);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        push(cyc + 1, 1, 0, 0, 4'd0, 0, 16'h0, 0);
        apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 2'd0, 1, 64'h0000_0000_0000_05A3);
        idle(TMO + 2);
    endtask

    initial begin
        test_reset();
        test_param();
        test_timeout();
        test_back_to_back();
        test_overrun();
        test_reset_wait();
        idle(3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
